regfile_nr2w1: RTL and testbench

Parametrised multi-register file that replaces the per-register cell-plus-tri-state arrangement with a single block.
- Holds NREG registers of WIDTH bits, with two combinational read ports (A, B) and one write port.
- Register ZERO_REG is optionally hardwired to zero.
- Adds a pending-write scoreboard so the datapath can detect read-after-write hazards on registers whose write-back has not yet occurred.
- Sits between decode (read addresses, issue) and write-back (write port) in the pipelined CPU.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_nr2w1.sv | 66 ++++++
 tb/tb_regfile_nr2w1.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, the address-width helper and the register index type
// for the two-read/one-write register file.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH    = 64;
    localparam int unsigned DEF_NREG     = 32;
    localparam int unsigned DEF_ZERO_REG = 31;

    function automatic int unsigned calc_aw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [calc_aw(DEF_NREG)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: issue sets, write-back clears, set wins on the same
// index, and the hardwired-zero register never becomes pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = DEF_NREG,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG,
    localparam int unsigned AW      = calc_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   aaddr,
    input  logic [AW-1:0]   baddr,
    output logic            a_busy,
    output logic            b_busy,
    output logic [NREG-1:0] pending
);

    logic [NREG-1:0] pending_nxt;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_EN && (32'(a) == ZERO_REG);
    endfunction

    // Clear first, then set, so a same-edge issue to the written index wins.
    always_comb begin
        pending_nxt = pending;
        if (wen)
            pending_nxt[waddr] = 1'b0;
        if (issue)
            pending_nxt[issue_rd] = 1'b1;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (is_zero(AW'(i)))
                pending_nxt[i] = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign a_busy = pending[aaddr];
    assign b_busy = pending[baddr];

endmodule

// File: rtl/regfile_nr2w1.sv
// NREG x WIDTH register file with two combinational read ports, one
// falling-edge write port, optional hardwired zero register and scoreboard.
module regfile_nr2w1
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned NREG     = DEF_NREG,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG,
    localparam int unsigned AW      = calc_aw(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] dbus,
    input  logic [AW-1:0]    aaddr,
    input  logic [AW-1:0]    baddr,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus,
    input  logic             issue,
    input  logic [AW-1:0]    issue_rd,
    output logic             a_busy,
    output logic             b_busy,
    output logic [NREG-1:0]  pending
);

    logic [WIDTH-1:0] regs [NREG];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_EN && (32'(a) == ZERO_REG);
    endfunction

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wen && !is_zero(waddr)) begin
            regs[waddr] <= dbus;
        end
    end

    // Writes land on the falling edge, so the second half-cycle sees them
    // through the plain read mux.
    assign abus = is_zero(aaddr) ? '0 : regs[aaddr];
    assign bbus = is_zero(baddr) ? '0 : regs[baddr];

    regfile_scoreboard #(
        .NREG     (NREG),
        .ZERO_EN  (ZERO_EN),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .waddr    (waddr),
        .issue    (issue),
        .issue_rd (issue_rd),
        .aaddr    (aaddr),
        .baddr    (baddr),
        .a_busy   (a_busy),
        .b_busy   (b_busy),
        .pending  (pending)
    );

endmodule

// File: tb/tb_regfile_nr2w1.sv
// Scoreboard bench for regfile_nr2w1: default 64x32 instance plus a
// 32-bit x 16 instance without a zero register.
module tb_regfile_nr2w1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        wen = 1'b0, issue = 1'b0;
    logic [4:0]  waddr = '0, aaddr = '0, baddr = '0, issue_rd = '0;
    logic [63:0] dbus = '0, abus, bbus;
    logic        a_busy, b_busy;
    logic [31:0] pending;

    // Small instance
    logic        wen2 = 1'b0, issue2 = 1'b0;
    logic [3:0]  waddr2 = '0, aaddr2 = '0, baddr2 = '0, issue_rd2 = '0;
    logic [31:0] dbus2 = '0, abus2, bbus2;
    logic        a_busy2, b_busy2;
    logic [15:0] pending2;

    regfile_nr2w1 dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .dbus(dbus),
        .aaddr(aaddr), .baddr(baddr), .abus(abus), .bbus(bbus),
        .issue(issue), .issue_rd(issue_rd), .a_busy(a_busy), .b_busy(b_busy),
        .pending(pending)
    );

    regfile_nr2w1 #(.WIDTH(32), .NREG(16), .ZERO_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wen(wen2), .waddr(waddr2), .dbus(dbus2),
        .aaddr(aaddr2), .baddr(baddr2), .abus(abus2), .bbus(bbus2),
        .issue(issue2), .issue_rd(issue_rd2), .a_busy(a_busy2), .b_busy(b_busy2),
        .pending(pending2)
    );

    typedef enum int { S_ABUS, S_BBUS, S_ABUSY, S_BBUSY, S_PEND,
                       S_ABUS2, S_PEND2, S_ABUSY2 } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] actual(input sel_t s);
        case (s)
            S_ABUS:   return abus;
            S_BBUS:   return bbus;
            S_ABUSY:  return {63'd0, a_busy};
            S_BBUSY:  return {63'd0, b_busy};
            S_PEND:   return {32'd0, pending};
            S_ABUS2:  return {32'd0, abus2};
            S_PEND2:  return {48'd0, pending2};
            S_ABUSY2: return {63'd0, a_busy2};
            default:  return 'x;
        endcase
    endfunction

    task automatic expect_val(input string name, input sel_t s, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.sel  = s;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Monitor samples on the rising edge, half a cycle after state updates.
    initial begin
        exp_t e;
        logic [63:0] act;
        forever begin
            @(posedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = actual(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step(input logic w, input int wa, input logic [63:0] d,
                        input logic is, input int rd, input int aa, input int ba);
        @(posedge clk); #1;
        wen = w; waddr = 5'(wa); dbus = d;
        issue = is; issue_rd = 5'(rd);
        aaddr = 5'(aa); baddr = 5'(ba);
        @(negedge clk); #1;
        wen = 1'b0; issue = 1'b0;
    endtask

    task automatic step2(input logic w, input int wa, input logic [31:0] d,
                         input logic is, input int rd, input int aa);
        @(posedge clk); #1;
        wen2 = w; waddr2 = 4'(wa); dbus2 = d;
        issue2 = is; issue_rd2 = 4'(rd);
        aaddr2 = 4'(aa); baddr2 = 4'(aa);
        @(negedge clk); #1;
        wen2 = 1'b0; issue2 = 1'b0;
    endtask

    initial begin
        int budget;
        #12 rst_n = 1'b1;
        expect_val("reset_abus", S_ABUS, 64'd0);
        expect_val("reset_pending", S_PEND, 64'd0);
        expect_val("reset_abusy", S_ABUSY, 64'd0);

        // Preload reg 5 and mark it pending, then reset between edges
        step(1, 5, 64'hDEAD, 1, 5, 5, 0);
        expect_val("preload_abus", S_ABUS, 64'hDEAD);
        expect_val("preload_pending", S_PEND, 64'h20);
        @(negedge clk); #1 rst_n = 1'b0;
        expect_val("midreset_abus", S_ABUS, 64'd0);
        expect_val("midreset_pending", S_PEND, 64'd0);
        expect_val("midreset_abusy", S_ABUSY, 64'd0);
        #6 rst_n = 1'b1;
        expect_val("postreset_abus", S_ABUS, 64'd0);
        expect_val("postreset_abusy", S_ABUSY, 64'd0);

        // Basic write / dual read
        step(1, 3, 64'h0123456789ABCDEF, 0, 0, 3, 3);
        expect_val("wr3_abus", S_ABUS, 64'h0123456789ABCDEF);
        expect_val("wr3_bbus", S_BBUS, 64'h0123456789ABCDEF);
        step(0, 0, 64'd0, 0, 0, 4, 3);
        expect_val("reg4_untouched", S_ABUS, 64'd0);
        expect_val("reg3_hold", S_BBUS, 64'h0123456789ABCDEF);

        // Zero register ignores writes and issues
        step(1, 31, '1, 1, 31, 31, 31);
        expect_val("zero_abus", S_ABUS, 64'd0);
        expect_val("zero_pending", S_PEND, 64'd0);
        expect_val("zero_abusy", S_ABUSY, 64'd0);
        expect_val("zero_bbusy", S_BBUSY, 64'd0);

        // Scoreboard lifecycle on reg 7
        step(0, 0, 64'd0, 1, 7, 7, 3);
        expect_val("iss7_pending", S_PEND, 64'h80);
        expect_val("iss7_abusy", S_ABUSY, 64'd1);
        expect_val("iss7_bbusy", S_BBUSY, 64'd0);
        step(1, 7, 64'h42, 0, 0, 7, 3);
        expect_val("wb7_pending", S_PEND, 64'd0);
        expect_val("wb7_abus", S_ABUS, 64'h42);
        expect_val("wb7_abusy", S_ABUSY, 64'd0);

        // Same-edge issue and write: same index keeps pending set
        step(0, 0, 64'd0, 1, 9, 9, 9);
        expect_val("iss9_pending", S_PEND, 64'h200);
        step(1, 9, 64'h99, 1, 9, 9, 9);
        expect_val("same_pending", S_PEND, 64'h200);
        expect_val("same_abus", S_ABUS, 64'h99);
        expect_val("same_bbus", S_BBUS, 64'h99);
        expect_val("same_abusy", S_ABUSY, 64'd1);
        expect_val("same_bbusy", S_BBUSY, 64'd1);
        step(1, 9, 64'h77, 1, 10, 9, 10);
        expect_val("diff_pending", S_PEND, 64'h400);
        expect_val("diff_abus", S_ABUS, 64'h77);
        expect_val("diff_abusy", S_ABUSY, 64'd0);
        expect_val("diff_bbusy", S_BBUSY, 64'd1);

        // Repeated issue, single write-back clears
        step(0, 0, 64'd0, 1, 10, 10, 10);
        expect_val("reiss_pending", S_PEND, 64'h400);
        step(1, 10, 64'h1010, 0, 0, 10, 10);
        expect_val("reiss_clear", S_PEND, 64'd0);
        expect_val("reiss_abus", S_ABUS, 64'h1010);

        // Write to non-pending register leaves pending clear
        step(1, 12, 64'hC, 0, 0, 12, 0);
        expect_val("np_pending", S_PEND, 64'd0);
        expect_val("np_abus", S_ABUS, 64'hC);

        // 32-bit x 16 instance, no zero register: reg 15 is ordinary
        step2(1, 3, 32'h89ABCDEF, 0, 0, 3);
        expect_val("p2_wr3", S_ABUS2, 64'h89ABCDEF);
        expect_val("p2_pend0", S_PEND2, 64'd0);
        step2(1, 15, 32'hFFFFFFFF, 1, 15, 15);
        expect_val("p2_wr15", S_ABUS2, 64'hFFFFFFFF);
        expect_val("p2_pend15", S_PEND2, 64'h8000);
        expect_val("p2_busy15", S_ABUSY2, 64'd1);
        step2(1, 15, 32'h5A, 0, 0, 15);
        expect_val("p2_wb15", S_ABUS2, 64'h5A);
        expect_val("p2_clr15", S_PEND2, 64'd0);
        expect_val("p2_idle15", S_ABUSY2, 64'd0);

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
